root_job_sequencer: RTL and testbench

//  Upstream front-end for the nth-root engine. Queues (radicand, degree, tag) jobs
//  and issues them one at a time over the engine's in_valid/in_data_1/in_data_2 pins.

---
 rtl/root_job_sequencer.sv | 165 ++++++++++++++++
 tb/tb_root_job_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/root_job_sequencer.sv
// Job front-end for the nth-root engine: queues (radicand, degree, tag) jobs,
// issues them one at a time, captures the Q10.10 result or a timeout, and
// returns responses in request order on a valid/ready port.
module root_job_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [9:0]       req_radicand,
    input  logic [2:0]       req_degree,
    input  logic [TAG_W-1:0] req_tag,
    output logic             root_in_valid,
    output logic [9:0]       root_in_data_1,
    output logic [2:0]       root_in_data_2,
    input  logic             root_out_valid,
    input  logic [19:0]      root_out_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [19:0]      rsp_root,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t state, state_next;

    // request queue; pointers carry an extra wrap bit to tell full from empty
    logic [9:0]       q_rad [FIFO_DEPTH];
    logic [2:0]       q_deg [FIFO_DEPTH];
    logic [TAG_W-1:0] q_tag [FIFO_DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             ready_q;
    logic             empty, full, push, pop;
    logic [9:0]       head_rad;
    logic [2:0]       head_deg;
    logic [TAG_W-1:0] head_tag;

    logic [CW-1:0]    tcnt;
    logic             ov_d, rise, timed_out;

    logic             in_valid_n, rsp_valid_n;
    logic [9:0]       data1_n;
    logic [2:0]       data2_n;
    logic [19:0]      root_n;
    logic [TAG_W-1:0] tag_n;
    logic [1:0]       err_n;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign req_ready = ready_q && !full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head_rad  = q_rad[rptr[AW-1:0]];
    assign head_deg  = q_deg[rptr[AW-1:0]];
    assign head_tag  = q_tag[rptr[AW-1:0]];

    // only a fresh rising edge of the engine's valid counts as a result
    assign rise      = root_out_valid && !ov_d;
    assign timed_out = (tcnt == CW'(TIMEOUT - 1));

    // queue pointers and storage; ready stays low through the reset cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) begin
                q_rad[wptr[AW-1:0]] <= req_radicand;
                q_deg[wptr[AW-1:0]] <= req_degree;
                q_tag[wptr[AW-1:0]] <= req_tag;
                wptr                <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // state register, WAIT cycle counter and engine-valid history
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
            ov_d  <= 1'b0;
        end else begin
            state <= state_next;
            ov_d  <= root_out_valid;
            if (state == WAIT && state_next == WAIT)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!empty) state_next = (head_deg == 3'd0) ? RESP : ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (rise || timed_out) state_next = RESP;
            RESP:  if (rsp_ready) state_next = (rsp_err == 2'b00) ? DRAIN : IDLE;
            DRAIN: if (!root_out_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // next values of the registered outputs; capture beats timeout in WAIT
    always_comb begin
        in_valid_n  = (state_next == ISSUE);
        rsp_valid_n = (state_next == RESP);
        data1_n     = root_in_data_1;
        data2_n     = root_in_data_2;
        root_n      = rsp_root;
        tag_n       = rsp_tag;
        err_n       = rsp_err;
        if (pop) begin
            data1_n = head_rad;
            data2_n = head_deg;
            tag_n   = head_tag;
            if (head_deg == 3'd0) begin
                root_n = '0;
                err_n  = 2'b01;
            end
        end
        if (state == WAIT) begin
            if (rise) begin
                root_n = root_out_data;
                err_n  = 2'b00;
            end else if (timed_out) begin
                root_n = '0;
                err_n  = 2'b10;
            end
        end
    end

    // output registers; job operands held from pop until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            root_in_valid  <= 1'b0;
            root_in_data_1 <= '0;
            root_in_data_2 <= '0;
            rsp_valid      <= 1'b0;
            rsp_root       <= '0;
            rsp_tag        <= '0;
            rsp_err        <= '0;
        end else begin
            root_in_valid  <= in_valid_n;
            root_in_data_1 <= data1_n;
            root_in_data_2 <= data2_n;
            rsp_valid      <= rsp_valid_n;
            rsp_root       <= root_n;
            rsp_tag        <= tag_n;
            rsp_err        <= err_n;
        end
    end
endmodule

// File: tb/tb_root_job_sequencer.sv
// Directed bench for root_job_sequencer with a small root-engine model.
module tb_root_job_sequencer;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [9:0]       req_radicand = '0;
    logic [2:0]       req_degree = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             root_in_valid;
    logic [9:0]       root_in_data_1;
    logic [2:0]       root_in_data_2;
    logic             root_out_valid;
    logic [19:0]      root_out_data;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [19:0]      rsp_root;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;

    int n_chk = 0;
    int n_fail = 0;

    root_job_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_radicand(req_radicand), .req_degree(req_degree), .req_tag(req_tag),
        .root_in_valid(root_in_valid), .root_in_data_1(root_in_data_1),
        .root_in_data_2(root_in_data_2),
        .root_out_valid(root_out_valid), .root_out_data(root_out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_root(rsp_root), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // engine model: result 3 cycles after in_valid, out_valid held 2 cycles
    logic       eng_mute = 1'b0;
    logic       stray = 1'b0;
    int         e_dly, e_hold;
    logic [19:0] e_res;

    function automatic logic [19:0] root_model(input int rad, input int deg);
        int r = 0;
        int p;
        forever begin
            p = 1;
            for (int k = 0; k < deg; k++) p = p * (r + 1);
            if (p > rad) break;
            r++;
        end
        return 20'(r << 10);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e_dly <= 0;
            e_hold <= 0;
            root_out_valid <= 1'b0;
            e_res <= '0;
        end else begin
            if (root_in_valid && !eng_mute) begin
                e_dly <= 3;
                e_res <= root_model(int'(root_in_data_1), int'(root_in_data_2));
            end else if (e_dly != 0) e_dly <= e_dly - 1;
            if (e_dly == 1) e_hold <= 2;
            else if (e_hold != 0) e_hold <= e_hold - 1;
            root_out_valid <= (e_dly == 1) || (e_hold > 1) || stray;
        end
    end
    assign root_out_data = e_res;

    // cycle counter and engine-issue monitor
    int cyc = 0, issue_cnt = 0, wait_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (root_in_valid) begin
            issue_cnt <= issue_cnt + 1;
            wait_cyc  <= cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int rad, input int deg, input int tag);
        logic ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_radicand = 10'(rad);
            req_degree = 3'(deg);
            req_tag = TAG_W'(tag);
            ok = req_ready;
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        if (!ok) check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(output logic [19:0] root, output logic [TAG_W-1:0] tag,
                            output logic [1:0] err, output int at);
        logic got = 1'b0;
        root = '0; tag = '0; err = '0; at = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                root = rsp_root; tag = rsp_tag; err = rsp_err; at = cyc;
                rsp_ready = 1'b1;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
            end
        end
        if (!got) check("rsp_wait", 32'(got), 32'd1);
    endtask

    logic [19:0]      r_root;
    logic [TAG_W-1:0] r_tag;
    logic [1:0]       r_err;
    int               r_at, base, acc, seen;

    initial begin
        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_in_valid", 32'(root_in_valid), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_outs", {root_in_data_1, root_in_data_2, rsp_tag, rsp_err}, 32'd0);
        check("rst_rsp_root", 32'(rsp_root), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // 1: 27 ^ (1/3) = 3.0
        base = issue_cnt;
        push(27, 3, 3);
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t1_root", 32'(r_root), 32'h00C00);
        check("t1_err", 32'(r_err), 32'd0);
        check("t1_tag", 32'(r_tag), 32'd3);
        check("t1_issue_once", 32'(issue_cnt - base), 32'd1);

        // 2: normal job then degree-zero job
        base = issue_cnt;
        push(16, 2, 5);
        push(100, 0, 6);
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t2a_root", 32'(r_root), 32'h01000);
        check("t2a_tag_err", {r_tag, r_err}, {4'd5, 2'b00});
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t2b_root", 32'(r_root), 32'h0);
        check("t2b_tag_err", {r_tag, r_err}, {4'd6, 2'b01});
        check("t2_issue_once", 32'(issue_cnt - base), 32'd1);

        // 3: stalled consumer, six back-to-back offers
        acc = 0;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_radicand = 10'(t * t);
            req_degree = 3'd2;
            req_tag = TAG_W'(t);
            if (req_ready) acc++;
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("t3_accepted", 32'(acc), 32'd5);
        check("t3_full_ready", 32'(req_ready), 32'd0);
        for (int t = 1; t <= 5; t++) begin
            wait_rsp(r_root, r_tag, r_err, r_at);
            check("t3_tag", 32'(r_tag), 32'(t));
            check("t3_root", 32'(r_root), 32'(t * 1024));
            check("t3_err", 32'(r_err), 32'd0);
            if (t == 1) begin
                repeat (4) @(negedge clk);
                check("t3_ready_back", 32'(req_ready), 32'd1);
            end
        end

        // 4: silent engine -> timeout, then a normal job
        eng_mute = 1'b1;
        push(50, 2, 8);
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t4_err", 32'(r_err), 32'd2);
        check("t4_root", 32'(r_root), 32'd0);
        check("t4_tag", 32'(r_tag), 32'd8);
        check("t4_latency", 32'(r_at - wait_cyc), 32'(TIMEOUT));
        eng_mute = 1'b0;
        push(64, 3, 2);
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t4_next_root", 32'(r_root), 32'h01000);
        check("t4_next_err", 32'(r_err), 32'd0);

        // 5: one capture per job, stray pulse in IDLE ignored
        push(81, 4, 4);
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t5_root", 32'(r_root), 32'h00C00);
        seen = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
        check("t5_no_double", 32'(seen), 32'd0);
        base = issue_cnt;
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        seen = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
        check("t5_stray_ignored", 32'(seen), 32'd0);
        check("t5_stray_no_issue", 32'(issue_cnt - base), 32'd0);
        push(1, 5, 11);
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t5_after_root", 32'(r_root), 32'h00400);
        check("t5_after_tag", 32'(r_tag), 32'd11);

        // 6: reset mid-WAIT with three queued
        eng_mute = 1'b1;
        push(100, 2, 9);
        push(4, 2, 10);
        push(9, 2, 12);
        push(25, 2, 13);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_valids", {30'd0, root_in_valid, rsp_valid}, 32'd0);
        check("t6_rst_outs", {root_in_data_1, root_in_data_2, rsp_tag, rsp_err}, 32'd0);
        check("t6_rst_root", 32'(rsp_root), 32'd0);
        rst = 1'b0;
        eng_mute = 1'b0;
        base = issue_cnt;
        repeat (6) @(negedge clk);
        check("t6_fifo_empty", {30'd0, rsp_valid, 1'b0}, 32'd0);
        check("t6_no_issue", 32'(issue_cnt - base), 32'd0);
        push(8, 3, 7);
        wait_rsp(r_root, r_tag, r_err, r_at);
        check("t6_root", 32'(r_root), 32'h00800);
        check("t6_tag_err", {r_tag, r_err}, {4'd7, 2'b00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule
